// File: rtl/pll_rst_pkg.sv
// -----------------------------------------------------------------------------
// pll_rst_pkg
// Shared definitions for the PLL reset sequencer:
//   - state_t      : sequencer FSM states
//   - outs_t       : bundle of the state-decoded status outputs
//   - DEF_*        : default timing parameters (16 MHz reference)
//   - state_outs() : output levels that apply on entry to each state
//   - max3()       : helper used to size the shared timer
// -----------------------------------------------------------------------------
package pll_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STRETCH,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam int DEF_RESETB_CYCLES  = 16;
  localparam int DEF_LOCK_TIMEOUT   = 16000;    // about 1 ms at 16 MHz
  localparam int DEF_STRETCH_CYCLES = 256;
  localparam int DEF_MAX_RETRY      = 3;
  localparam int DEF_HB_HALF        = 8000000;

  typedef struct packed {
    logic pll_resetb;
    logic sys_reset;
    logic locked;
    logic fault;
    logic heartbeat;
  } outs_t;

  // Output levels on entry to a state. The heartbeat starts at 0 in RUN and
  // is then toggled by the divider; FAULT drives it solidly on.
  function automatic outs_t state_outs(input state_t st);
    outs_t o;
    o = '{pll_resetb: 1'b1, sys_reset: 1'b1, locked: 1'b0,
          fault: 1'b0, heartbeat: 1'b0};
    case (st)
      ST_PLL_RST:   o.pll_resetb = 1'b0;
      ST_WAIT_LOCK: o.pll_resetb = 1'b1;
      ST_STRETCH:   o.pll_resetb = 1'b1;
      ST_RUN: begin
        o.sys_reset = 1'b0;
        o.locked    = 1'b1;
      end
      ST_FAULT: begin
        o.pll_resetb = 1'b0;
        o.fault      = 1'b1;
        o.heartbeat  = 1'b1;
      end
      default:      o.pll_resetb = 1'b0;
    endcase
    return o;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk   in  reference clock
//   reset in  synchronous active-high reset (both flops cleared to 0)
//   d_i   in  asynchronous input level
//   q_o   out synchronized level, two clk edges behind d_i
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
// PLL bring-up and system reset sequencer. Pulses the PLL RESETB, waits for
// lock (with timeout and bounded retries), requires lock to stay stable for
// STRETCH_CYCLES before releasing the CPU reset, watches for lock loss while
// running, and latches a FAULT state when retries are exhausted.
// Ports:
//   clk             in   16 MHz reference clock (only clock)
//   reset           in   synchronous active-high reset
//   pll_lock_i      in   PLL LOCK, asynchronous
//   pll_resetb_o    out  active-low PLL RESETB
//   sys_reset_o     out  active-high CPU-domain reset request
//   locked_o        out  high while running
//   fault_o         out  high while in fault
//   retry_cnt_o     out  [1:0] current retry count
//   lock_loss_cnt_o out  [7:0] saturating count of lock losses while running
//   heartbeat_o     out  status LED drive
// All outputs come straight from flops; pll_lock_i only reaches logic through
// the synchronizer.
// -----------------------------------------------------------------------------
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int RESETB_CYCLES  = DEF_RESETB_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int HB_HALF        = DEF_HB_HALF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock_i,
  output logic       pll_resetb_o,
  output logic       sys_reset_o,
  output logic       locked_o,
  output logic       fault_o,
  output logic [1:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o,
  output logic       heartbeat_o
);

  // One timer shared by every timed state; it is loaded with (N-1) on entry
  // and the state's exit condition fires when it reaches zero.
  localparam int CNT_MAX = max3(RESETB_CYCLES, LOCK_TIMEOUT, STRETCH_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int HB_W    = $clog2(HB_HALF + 1);

  localparam logic [CNT_W-1:0] LD_RESETB  = CNT_W'(RESETB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_STRETCH = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [HB_W-1:0]  HB_LD      = HB_W'(HB_HALF - 1);
  localparam logic [HB_W-1:0]  HB_ONE     = HB_W'(1);
  localparam logic [1:0]       RETRY_LIM  = 2'(MAX_RETRY);

  logic             w_lock_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [HB_W-1:0]  r_hb_cnt;
  logic [1:0]       r_retry;
  logic [7:0]       r_loss;
  outs_t            r_outs;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pll_lock_i),
    .q_o   (w_lock_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_PLL_RST;
      r_cnt    <= LD_RESETB;
      r_hb_cnt <= HB_LD;
      r_retry  <= 2'd0;
      r_loss   <= 8'd0;
      r_outs   <= state_outs(ST_PLL_RST);
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == '0) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= LD_TIMEOUT;
            r_outs  <= state_outs(ST_WAIT_LOCK);
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock is tested before the timeout so a lock arriving on the
          // final timeout cycle still counts.
          if (w_lock_s) begin
            r_state <= ST_STRETCH;
            r_cnt   <= LD_STRETCH;
            r_outs  <= state_outs(ST_STRETCH);
          end else if (r_cnt == '0) begin
            if (r_retry == RETRY_LIM) begin
              r_state <= ST_FAULT;
              r_cnt   <= '0;
              r_outs  <= state_outs(ST_FAULT);
            end else begin
              r_state <= ST_PLL_RST;
              r_cnt   <= LD_RESETB;
              r_retry <= r_retry + 2'd1;
              r_outs  <= state_outs(ST_PLL_RST);
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_STRETCH: begin
          // A drop of lock beats stretch completion; the lock-loss counter
          // only tracks losses after the system has been released.
          if (!w_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= LD_TIMEOUT;
            r_outs  <= state_outs(ST_WAIT_LOCK);
          end else if (r_cnt == '0) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_hb_cnt <= HB_LD;
            r_retry  <= 2'd0;
            r_outs   <= state_outs(ST_RUN);
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_RUN: begin
          if (!w_lock_s) begin
            r_state <= ST_PLL_RST;
            r_cnt   <= LD_RESETB;
            r_outs  <= state_outs(ST_PLL_RST);
            if (r_loss != 8'hFF) begin
              r_loss <= r_loss + 8'd1;
            end
          end else if (r_hb_cnt == '0) begin
            r_hb_cnt         <= HB_LD;
            r_outs.heartbeat <= ~r_outs.heartbeat;
          end else begin
            r_hb_cnt <= r_hb_cnt - HB_ONE;
          end
        end

        ST_FAULT: begin
          // Terminal until an external reset.
          r_state <= ST_FAULT;
        end

        default: begin
          r_state <= ST_PLL_RST;
          r_cnt   <= LD_RESETB;
          r_outs  <= state_outs(ST_PLL_RST);
        end
      endcase
    end
  end

  assign pll_resetb_o    = r_outs.pll_resetb;
  assign sys_reset_o     = r_outs.sys_reset;
  assign locked_o        = r_outs.locked;
  assign fault_o         = r_outs.fault;
  assign heartbeat_o     = r_outs.heartbeat;
  assign retry_cnt_o     = r_retry;
  assign lock_loss_cnt_o = r_loss;

endmodule

// File: tb/tb_pll_rst_seq.sv
module tb_pll_rst_seq;

  localparam int R  = 4;
  localparam int S  = 8;
  localparam int T  = 20;
  localparam int MR = 2;
  localparam int HB = 5;

  // Phase names for the reference model (independent of the DUT encoding).
  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STR  = 2;
  localparam int P_RUN  = 3;
  localparam int P_FLT  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       pll_resetb_o;
  logic       sys_reset_o;
  logic       locked_o;
  logic       fault_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;
  logic       heartbeat_o;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .RESETB_CYCLES  (R),
    .LOCK_TIMEOUT   (T),
    .STRETCH_CYCLES (S),
    .MAX_RETRY      (MR),
    .HB_HALF        (HB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_lock_i      (pll_lock_i),
    .pll_resetb_o    (pll_resetb_o),
    .sys_reset_o     (sys_reset_o),
    .locked_o        (locked_o),
    .fault_o         (fault_o),
    .retry_cnt_o     (retry_cnt_o),
    .lock_loss_cnt_o (lock_loss_cnt_o),
    .heartbeat_o     (heartbeat_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit valid  = 0;

  // Reference model: phase plus time spent in it, lock seen two edges late.
  int m_ph = P_RST;
  int m_el = 0;
  int m_retry = 0;
  int m_loss = 0;
  bit h0 = 0, h1 = 0, ls = 0, moved = 0;
  bit s_rst = 0, s_pin = 0;
  bit e_rb, e_sr, e_lk, e_ft, e_hb;

  initial begin
    forever begin
      @(posedge clk);
      s_rst = reset;
      s_pin = pll_lock_i;
      if (s_rst) begin
        valid = 1; cyc = 0;
        m_ph = P_RST; m_el = 0; m_retry = 0; m_loss = 0;
        h0 = 0; h1 = 0;
      end else begin
        cyc++;
        ls = h1; h1 = h0; h0 = s_pin;
        moved = 0;
        case (m_ph)
          P_RST:  if (m_el == R - 1) begin m_ph = P_WAIT; moved = 1; end
          P_WAIT: if (ls) begin m_ph = P_STR; moved = 1; end
                  else if (m_el == T - 1) begin
                    if (m_retry == MR) m_ph = P_FLT;
                    else begin m_ph = P_RST; m_retry++; end
                    moved = 1;
                  end
          P_STR:  if (!ls) begin m_ph = P_WAIT; moved = 1; end
                  else if (m_el == S - 1) begin m_ph = P_RUN; m_retry = 0; moved = 1; end
          P_RUN:  if (!ls) begin
                    m_ph = P_RST; moved = 1;
                    if (m_loss < 255) m_loss++;
                  end
          default: ;
        endcase
        m_el = moved ? 0 : m_el + 1;
      end
      #1;
      if (valid) begin
        e_rb = !(m_ph == P_RST || m_ph == P_FLT);
        e_sr = (m_ph != P_RUN);
        e_lk = (m_ph == P_RUN);
        e_ft = (m_ph == P_FLT);
        e_hb = (m_ph == P_FLT) ? 1'b1 :
               (m_ph == P_RUN) ? (((m_el / HB) % 2) == 1) : 1'b0;
        checks++;
        if (pll_resetb_o !== e_rb || sys_reset_o !== e_sr || locked_o !== e_lk ||
            fault_o !== e_ft || heartbeat_o !== e_hb ||
            retry_cnt_o !== 2'(m_retry) || lock_loss_cnt_o !== 8'(m_loss)) begin
          errors++;
          $display("FAIL model cyc=%0d got rb=%b sr=%b lk=%b ft=%b hb=%b rt=%0d ll=%0d required rb=%b sr=%b lk=%b ft=%b hb=%b rt=%0d ll=%0d",
                   cyc, pll_resetb_o, sys_reset_o, locked_o, fault_o, heartbeat_o,
                   retry_cnt_o, lock_loss_cnt_o, e_rb, e_sr, e_lk, e_ft, e_hb, m_retry, m_loss);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, exp);
    end else begin
      $display("ok   %s cyc=%0d value=%0d", name, cyc, got);
    end
  endtask

  // Advance (at negedges) until the cycle counter reaches n, bounded.
  task automatic wait_cyc(input int n);
    for (int k = 0; k < 5000 && cyc != n; k++) @(negedge clk);
    if (cyc != n) begin
      checks++; errors++;
      $display("FAIL wait_cyc target=%0d got=%0d", n, cyc);
    end
  endtask

  task automatic wait_level(input bit lvl, input string name);
    for (int k = 0; k < 200 && locked_o !== lvl; k++) @(negedge clk);
    if (locked_o !== lvl) begin
      checks++; errors++;
      $display("FAIL %s timeout got=%b required=%b", name, locked_o, lvl);
    end
  endtask

  // Ends at the negedge of cycle 0 after release.
  task automatic do_reset(input bit pin);
    @(negedge clk);
    reset = 1'b1;
    pll_lock_i = pin;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_resetb"}, pll_resetb_o, 0);
    chk({tag, "_sysrst"}, sys_reset_o, 1);
    chk({tag, "_locked"}, locked_o, 0);
    chk({tag, "_fault"},  fault_o, 0);
    chk({tag, "_hb"},     heartbeat_o, 0);
    chk({tag, "_retry"},  retry_cnt_o, 0);
    chk({tag, "_loss"},   lock_loss_cnt_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lock high throughout.
    reset = 1'b1; pll_lock_i = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("por");
    wait_cyc(3);  chk("rb_c3", pll_resetb_o, 0);
    wait_cyc(4);  chk("rb_c4", pll_resetb_o, 1);
    wait_cyc(12); chk("sr_c12", sys_reset_o, 1);
    wait_cyc(13); chk("sr_c13", sys_reset_o, 0); chk("lk_c13", locked_o, 1);
    wait_cyc(17); chk("hb_c17", heartbeat_o, 0);
    wait_cyc(18); chk("hb_c18", heartbeat_o, 1);
    wait_cyc(23); chk("hb_c23", heartbeat_o, 0);
    wait_cyc(28); chk("hb_c28", heartbeat_o, 1);

    // One-cycle lock drop in RUN.
    wait_cyc(30); pll_lock_i = 1'b0;
    @(negedge clk); pll_lock_i = 1'b1;
    wait_cyc(33); chk("drop_sr", sys_reset_o, 1); chk("drop_loss", lock_loss_cnt_o, 1);
    chk("drop_rb", pll_resetb_o, 0);
    wait_cyc(36); chk("drop_rb_c36", pll_resetb_o, 0);
    wait_cyc(37); chk("drop_rb_c37", pll_resetb_o, 1);
    wait_cyc(45); chk("drop_sr_c45", sys_reset_o, 1);
    wait_cyc(46); chk("drop_sr_c46", sys_reset_o, 0);

    // Lock glitch at the 5th STRETCH cycle.
    do_reset(1'b1);
    wait_cyc(7); pll_lock_i = 1'b0;
    @(negedge clk); pll_lock_i = 1'b1;
    wait_cyc(13); chk("gl_sr_c13", sys_reset_o, 1);
    wait_cyc(18); chk("gl_sr_c18", sys_reset_o, 1);
    wait_cyc(19); chk("gl_sr_c19", sys_reset_o, 0); chk("gl_loss", lock_loss_cnt_o, 0);

    // Reset in the middle of STRETCH.
    do_reset(1'b1);
    wait_cyc(8); reset = 1'b1;
    @(negedge clk); chk_reset_vals("midstr");
    @(negedge clk); reset = 1'b0;
    wait_cyc(13); chk("midstr_lk", locked_o, 1);

    // Lock never arrives: retries then FAULT.
    do_reset(1'b0);
    wait_cyc(23); chk("nl_rb_c23", pll_resetb_o, 1);
    wait_cyc(24); chk("nl_rb_c24", pll_resetb_o, 0); chk("nl_rt_c24", retry_cnt_o, 1);
    wait_cyc(48); chk("nl_rb_c48", pll_resetb_o, 0); chk("nl_rt_c48", retry_cnt_o, 2);
    wait_cyc(71); chk("nl_ft_c71", fault_o, 0);
    wait_cyc(72); chk("nl_ft_c72", fault_o, 1); chk("nl_hb_c72", heartbeat_o, 1);
    wait_cyc(120); chk("nl_ft_c120", fault_o, 1); chk("nl_rb_c120", pll_resetb_o, 0);

    // Reset out of FAULT, then full sequence again.
    pll_lock_i = 1'b1; reset = 1'b1;
    @(negedge clk); chk_reset_vals("flt");
    @(negedge clk); reset = 1'b0;
    wait_cyc(13); chk("flt_lk_c13", locked_o, 1);

    // 260 lock losses: counter saturates.
    for (int n = 0; n < 260; n++) begin
      wait_level(1'b1, "sat_lock");
      pll_lock_i = 1'b0;
      @(negedge clk); pll_lock_i = 1'b1;
      wait_level(1'b0, "sat_unlock");
    end
    wait_level(1'b1, "sat_final");
    chk("sat_loss", lock_loss_cnt_o, 255);

    // Randomized lock activity with occasional resets.
    for (int t = 0; t < 3000; ) begin
      int hold;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        hold = $urandom_range(1, 2);
      end else begin
        reset = 1'b0;
        pll_lock_i = ($urandom_range(0, 3) != 0);
        hold = pll_lock_i ? $urandom_range(1, 40) : $urandom_range(1, 60);
      end
      repeat (hold) @(negedge clk);
      t += hold;
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
